// File: rtl/jt900h_memctl.sv
// External-bus access unit: splits byte/word/long requests into aligned 8/16-bit
// little-endian bus beats with fixed and external wait states.
module jt900h_memctl #(
   parameter int unsigned BW   = 16,
   parameter int unsigned AW   = 24,
   parameter int unsigned WAIT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            req,
   input  logic            wr,
   input  logic [1:0]      size,
   input  logic [AW-1:0]   addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   bus_addr,
   output logic [BW-1:0]   bus_din,
   input  logic [BW-1:0]   bus_dout,
   output logic [BW/8-1:0] bus_we,
   output logic            bus_rd,
   input  logic            bus_wait
);
   localparam int unsigned LB = BW / 8;

   typedef enum logic [1:0] {IDLE, BEAT, LAST} state_t;
   state_t state, state_nx;

   logic [2:0]    k, k_nx, n, n_nx, cnt, cnt_nx, nb, nb_nx;
   logic          off, off_nx, wr_r, wr_nx;
   logic [AW-1:0] base, base_nx;
   logic [31:0]   wd_r, wd_nx, acc, acc_nx, rdata_nx;
   logic          busy_nx, done_nx, rd_nx;
   logic [AW-1:0] baddr_nx;
   logic [BW-1:0] din_nx;
   logic [LB-1:0] we_nx;

   logic [2:0]    in_nb, in_n, src_k, src_nb;
   logic          in_off, src_off, src_wr, beat_end;
   logic [AW-1:0] in_base, src_base, drv_addr;
   logic [31:0]   src_wd, cap;
   logic [BW-1:0] drv_din;
   logic [LB-1:0] drv_we;
   int            jd, jc;

   // Decode the incoming request: byte count, lane offset and beat count
   always_comb begin
      in_nb   = (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;
      in_off  = (LB == 2) ? addr[0] : 1'b0;
      in_base = (LB == 2) ? {addr[AW-1:1], 1'b0} : addr;
      in_n    = 3'((int'(in_off) + int'(in_nb) + int'(LB) - 1) / int'(LB));
   end

   assign beat_end = (cnt == 3'd0) && !bus_wait;

   // Beat to drive next: beat 0 of a new request, or the following beat of the current one
   always_comb begin
      src_k    = (state == IDLE) ? 3'd0 : k + 3'd1;
      src_base = (state == IDLE) ? in_base : base;
      src_off  = (state == IDLE) ? in_off : off;
      src_nb   = (state == IDLE) ? in_nb : nb;
      src_wd   = (state == IDLE) ? wdata : wd_r;
      src_wr   = (state == IDLE) ? wr : wr_r;
      drv_addr = src_base + AW'(int'(src_k) * int'(LB));
      drv_din  = '0;
      drv_we   = '0;
      jd       = 0;
      for (int l = 0; l < int'(LB); l++) begin
         jd = int'(src_k) * int'(LB) + l - int'(src_off);
         if (src_wr && jd >= 0 && jd < int'(src_nb)) begin
            drv_din[8*l +: 8] = src_wd[8*jd[1:0] +: 8];
            drv_we[l]         = 1'b1;
         end
      end
   end

   // Merge the requested lanes of the current beat into the read accumulator
   always_comb begin
      cap = acc;
      jc  = 0;
      for (int l = 0; l < int'(LB); l++) begin
         jc = int'(k) * int'(LB) + l - int'(off);
         if (jc >= 0 && jc < int'(nb))
            cap[8*jc[1:0] +: 8] = bus_dout[8*l +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= IDLE;
      else if (cen) state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = (in_n > 3'd1) ? BEAT : LAST;
         BEAT:    if (beat_end) state_nx = (k + 3'd2 == n) ? LAST : BEAT;
         LAST:    if (beat_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy_nx  = busy;
      done_nx  = 1'b0;
      rd_nx    = bus_rd;
      baddr_nx = bus_addr;
      din_nx   = bus_din;
      we_nx    = bus_we;
      rdata_nx = rdata;
      acc_nx   = acc;
      k_nx     = k;
      n_nx     = n;
      cnt_nx   = cnt;
      nb_nx    = nb;
      off_nx   = off;
      wr_nx    = wr_r;
      base_nx  = base;
      wd_nx    = wd_r;
      case (state)
         IDLE: if (req) begin
            wr_nx    = wr;
            nb_nx    = in_nb;
            off_nx   = in_off;
            base_nx  = in_base;
            wd_nx    = wdata;
            n_nx     = in_n;
            k_nx     = 3'd0;
            cnt_nx   = 3'(WAIT);
            acc_nx   = '0;
            busy_nx  = 1'b1;
            rd_nx    = !wr;
            baddr_nx = drv_addr;
            din_nx   = drv_din;
            we_nx    = drv_we;
         end
         BEAT, LAST: begin
            if (beat_end) begin
               acc_nx = cap;
               if (state == LAST) begin
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  rd_nx    = 1'b0;
                  baddr_nx = '0;
                  din_nx   = '0;
                  we_nx    = '0;
                  if (!wr_r) rdata_nx = cap;
               end else begin
                  k_nx     = k + 3'd1;
                  cnt_nx   = 3'(WAIT);
                  baddr_nx = drv_addr;
                  din_nx   = drv_din;
                  we_nx    = drv_we;
               end
            end else if (cnt != 3'd0) begin
               cnt_nx = cnt - 3'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0; busy <= 1'b0; done <= 1'b0; bus_rd <= 1'b0;
         bus_addr <= '0; bus_din <= '0; bus_we <= '0;
         acc <= '0; k <= '0; n <= '0; cnt <= '0; nb <= '0;
         off <= 1'b0; wr_r <= 1'b0; base <= '0; wd_r <= '0;
      end else if (cen) begin
         rdata <= rdata_nx; busy <= busy_nx; done <= done_nx; bus_rd <= rd_nx;
         bus_addr <= baddr_nx; bus_din <= din_nx; bus_we <= we_nx;
         acc <= acc_nx; k <= k_nx; n <= n_nx; cnt <= cnt_nx; nb <= nb_nx;
         off <= off_nx; wr_r <= wr_nx; base <= base_nx; wd_r <= wd_nx;
      end
   end
endmodule

// File: tb/tb_jt900h_memctl.sv
// Bench for jt900h_memctl: three instances (16-bit/no wait, 8-bit/no wait, 16-bit/2 waits)
// sharing a byte memory model, driven by a vector table plus directed corner sequences.
module tb_jt900h_memctl;
   localparam int LOGN = 128;

   logic        clk = 1'b0, rst, cen, wr, gate;
   logic [1:0]  size;
   logic [23:0] addr;
   logic [31:0] wdata;
   logic [2:0]  req_v, wait_v;
   logic        last_cen;

   logic [31:0] rdata_a, rdata_b, rdata_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic        bus_rd_a, bus_rd_b, bus_rd_c;
   logic [23:0] bus_addr_a, bus_addr_b, bus_addr_c;
   logic [15:0] bus_din_a, bus_din_c, bus_dout_a, bus_dout_c;
   logic [7:0]  bus_din_b, bus_dout_b;
   logic [1:0]  bus_we_a, bus_we_c;
   logic [0:0]  bus_we_b;

   logic [7:0]  mem [256];

   always #5 clk = ~clk;

   jt900h_memctl #(.BW(16), .AW(24), .WAIT(0)) u_a (
      .clk(clk), .rst(rst), .cen(cen), .req(req_v[0]), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .rdata(rdata_a), .busy(busy_a), .done(done_a), .bus_addr(bus_addr_a),
      .bus_din(bus_din_a), .bus_dout(bus_dout_a), .bus_we(bus_we_a), .bus_rd(bus_rd_a),
      .bus_wait(wait_v[0]));
   jt900h_memctl #(.BW(8), .AW(24), .WAIT(0)) u_b (
      .clk(clk), .rst(rst), .cen(cen), .req(req_v[1]), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .rdata(rdata_b), .busy(busy_b), .done(done_b), .bus_addr(bus_addr_b),
      .bus_din(bus_din_b), .bus_dout(bus_dout_b), .bus_we(bus_we_b), .bus_rd(bus_rd_b),
      .bus_wait(wait_v[1]));
   jt900h_memctl #(.BW(16), .AW(24), .WAIT(2)) u_c (
      .clk(clk), .rst(rst), .cen(cen), .req(req_v[2]), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .rdata(rdata_c), .busy(busy_c), .done(done_c), .bus_addr(bus_addr_c),
      .bus_din(bus_din_c), .bus_dout(bus_dout_c), .bus_we(bus_we_c), .bus_rd(bus_rd_c),
      .bus_wait(wait_v[2]));

   assign bus_dout_a = {mem[bus_addr_a[7:0] | 8'h01], mem[bus_addr_a[7:0] & 8'hFE]};
   assign bus_dout_c = {mem[bus_addr_c[7:0] | 8'h01], mem[bus_addr_c[7:0] & 8'hFE]};
   assign bus_dout_b = mem[bus_addr_b[7:0]];

   logic [2:0]  busy_v, done_v, mon_act;
   logic [31:0] rdata_v [3];
   logic [23:0] mon_addr [3];
   logic [1:0]  mon_we [3];
   logic [15:0] mon_din [3];
   assign busy_v = {busy_c, busy_b, busy_a};
   assign done_v = {done_c, done_b, done_a};
   assign rdata_v[0] = rdata_a;
   assign rdata_v[1] = rdata_b;
   assign rdata_v[2] = rdata_c;
   assign mon_addr[0] = bus_addr_a;
   assign mon_addr[1] = bus_addr_b;
   assign mon_addr[2] = bus_addr_c;
   assign mon_we[0] = bus_we_a;
   assign mon_we[1] = {1'b0, bus_we_b};
   assign mon_we[2] = bus_we_c;
   assign mon_din[0] = bus_din_a;
   assign mon_din[1] = {8'h00, bus_din_b};
   assign mon_din[2] = bus_din_c;
   assign mon_act = {bus_rd_c | (|bus_we_c), bus_rd_b | bus_we_b[0], bus_rd_a | (|bus_we_a)};

   // Beat log: one entry per distinct beat, with its length in cen edges
   int          log_len [3];
   int          done_cnt [3];
   logic [23:0] lg_addr [3][LOGN];
   logic [1:0]  lg_we [3][LOGN];
   logic [15:0] lg_din [3][LOGN];
   logic        lg_rd [3][LOGN];
   int          lg_dur [3][LOGN];
   logic        prev_act [3];
   logic [23:0] prev_addr [3];

   always @(posedge clk) last_cen <= cen;

   always @(negedge clk) begin
      if (last_cen && !rst) begin
         for (int i = 0; i < 3; i++) begin
            if (mon_act[i]) begin
               if (!prev_act[i] || mon_addr[i] != prev_addr[i]) begin
                  if (log_len[i] < LOGN) begin
                     lg_addr[i][log_len[i]] = mon_addr[i];
                     lg_we[i][log_len[i]]   = mon_we[i];
                     lg_din[i][log_len[i]]  = mon_din[i];
                     lg_rd[i][log_len[i]]   = (mon_we[i] == 2'b00);
                     lg_dur[i][log_len[i]]  = 1;
                  end
                  log_len[i]++;
               end else if (log_len[i] > 0 && log_len[i] <= LOGN) begin
                  lg_dur[i][log_len[i]-1]++;
               end
            end
            prev_act[i]  = mon_act[i];
            prev_addr[i] = mon_addr[i];
            if (done_v[i]) done_cnt[i]++;
         end
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (gate) cen = ~cen;
      else      cen = 1'b1;
   endtask

   task automatic run(input int sel, input logic w, input logic [1:0] sz, input logic [23:0] a,
                      input logic [31:0] wd, input int ws_from, input int ws_len,
                      output int lat, output int b0, output int nb);
      int g;
      b0 = log_len[sel];
      wr = w; size = sz; addr = a; wdata = wd;
      req_v[sel] = 1'b1;
      g = 0;
      while (!busy_v[sel] && g < 100) begin step(); g++; end
      req_v[sel] = 1'b0;
      if (!busy_v[sel]) chk("accept_timeout", 32'(busy_v[sel]), 32'd1);
      lat = 0;
      g = 0;
      while (!done_v[sel] && g < 200) begin
         step();
         g++;
         if (last_cen) lat++;
         if (ws_len > 0) begin
            if (lat == ws_from) wait_v[sel] = 1'b1;
            if (lat == ws_from + ws_len) wait_v[sel] = 1'b0;
         end
      end
      if (!done_v[sel]) chk("done_timeout", 32'(done_v[sel]), 32'd1);
      g = 0;
      do begin step(); g++; end while (!last_cen && g < 50);
      chk("done_fall", 32'(done_v[sel]), 32'd0);
      nb = log_len[sel] - b0;
   endtask

   typedef struct {
      int          sel;
      logic        w;
      logic [1:0]  sz;
      logic [23:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_n;
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];
   int   b0s [12];

   initial begin
      int lat, b0, nb, dc;
      vecs[0]  = '{0, 1'b0, 2'd2, 24'h000100, 32'h0,        32'h44332211, 2, 2};
      vecs[1]  = '{0, 1'b0, 2'd0, 24'h000003, 32'h0,        32'h00000044, 1, 1};
      vecs[2]  = '{0, 1'b0, 2'd1, 24'h000001, 32'h0,        32'h00003322, 2, 2};
      vecs[3]  = '{0, 1'b0, 2'd1, 24'h000012, 32'h0,        32'h00001312, 1, 1};
      vecs[4]  = '{0, 1'b0, 2'd2, 24'h000011, 32'h0,        32'h14131211, 3, 3};
      vecs[5]  = '{0, 1'b0, 2'd3, 24'h000020, 32'h0,        32'h23222120, 2, 2};
      vecs[6]  = '{0, 1'b1, 2'd2, 24'h000201, 32'hAABBCCDD, 32'h23222120, 3, 3};
      vecs[7]  = '{1, 1'b0, 2'd2, 24'hFFFFFE, 32'h0,        32'h2211FFFE, 4, 4};
      vecs[8]  = '{1, 1'b0, 2'd1, 24'h000005, 32'h0,        32'h00000605, 2, 2};
      vecs[9]  = '{1, 1'b1, 2'd0, 24'h000007, 32'h1234565A, 32'h00000605, 1, 1};
      vecs[10] = '{2, 1'b0, 2'd1, 24'h000012, 32'h0,        32'h00001312, 1, 3};
      vecs[11] = '{2, 1'b0, 2'd0, 24'h000013, 32'h0,        32'h00000013, 1, 3};

      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

      rst = 1'b1; cen = 1'b1; gate = 1'b0; req_v = '0; wait_v = '0;
      wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
      step(); step();
      chk("rst_rdata", rdata_a, 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_done", 32'(done_a), 32'h0);
      chk("rst_bus_addr", 32'(bus_addr_a), 32'h0);
      chk("rst_bus_we", 32'(bus_we_a), 32'h0);
      chk("rst_bus_rd", 32'(bus_rd_a), 32'h0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 12; i++) begin
         run(vecs[i].sel, vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, 0, 0, lat, b0, nb);
         b0s[i] = b0;
         chk($sformatf("v%0d_rdata", i), rdata_v[vecs[i].sel], vecs[i].exp_rd);
         chk($sformatf("v%0d_beats", i), 32'(nb), 32'(vecs[i].exp_n));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      end

      chk("v0_addr0", 32'(lg_addr[0][b0s[0]]), 32'h100);
      chk("v0_addr1", 32'(lg_addr[0][b0s[0]+1]), 32'h102);
      chk("v0_rd", 32'(lg_rd[0][b0s[0]]), 32'h1);
      chk("wr_b0_addr", 32'(lg_addr[0][b0s[6]]), 32'h200);
      chk("wr_b0_we", 32'(lg_we[0][b0s[6]]), 32'h2);
      chk("wr_b0_din", 32'(lg_din[0][b0s[6]]), 32'hDD00);
      chk("wr_b1_addr", 32'(lg_addr[0][b0s[6]+1]), 32'h202);
      chk("wr_b1_we", 32'(lg_we[0][b0s[6]+1]), 32'h3);
      chk("wr_b1_din", 32'(lg_din[0][b0s[6]+1]), 32'hBBCC);
      chk("wr_b2_addr", 32'(lg_addr[0][b0s[6]+2]), 32'h204);
      chk("wr_b2_we", 32'(lg_we[0][b0s[6]+2]), 32'h1);
      chk("wr_b2_din", 32'(lg_din[0][b0s[6]+2]), 32'h00AA);
      chk("wrap_a0", 32'(lg_addr[1][b0s[7]]), 32'hFFFFFE);
      chk("wrap_a1", 32'(lg_addr[1][b0s[7]+1]), 32'hFFFFFF);
      chk("wrap_a2", 32'(lg_addr[1][b0s[7]+2]), 32'h000000);
      chk("wrap_a3", 32'(lg_addr[1][b0s[7]+3]), 32'h000001);
      chk("b8_wr_din", 32'(lg_din[1][b0s[9]]), 32'h5A);
      chk("b8_wr_we", 32'(lg_we[1][b0s[9]]), 32'h1);

      // WAIT=2 odd word read, external stall of 2 cycles on beat 1
      run(2, 1'b0, 2'd1, 24'h000011, 32'h0, 5, 2, lat, b0, nb);
      chk("ws_latency", 32'(lat), 32'd8);
      chk("ws_beats", 32'(nb), 32'd2);
      chk("ws_dur0", 32'(lg_dur[2][b0]), 32'd3);
      chk("ws_dur1", 32'(lg_dur[2][b0+1]), 32'd5);
      chk("ws_rd0", 32'(lg_rd[2][b0]), 32'd1);
      chk("ws_rd1", 32'(lg_rd[2][b0+1]), 32'd1);
      chk("ws_rdata", rdata_c, 32'h00001211);

      // cen toggling every cycle must not change the result or beat count
      gate = 1'b1;
      run(0, 1'b0, 2'd2, 24'h000011, 32'h0, 0, 0, lat, b0, nb);
      gate = 1'b0;
      step();
      chk("gate_rdata", rdata_a, 32'h14131211);
      chk("gate_beats", 32'(nb), 32'd3);
      chk("gate_latency", 32'(lat), 32'd3);
      chk("gate_dur", 32'(lg_dur[0][b0+1]), 32'd1);

      // req held high: one idle cycle between accesses, changes during busy ignored
      wr = 1'b0; size = 2'd0; addr = 24'h000002; req_v[0] = 1'b1;
      dc = 0;
      while (!busy_a && dc < 20) begin step(); dc++; end
      addr = 24'h000003;
      step();
      chk("b2b_done1", 32'(done_a), 32'd1);
      chk("b2b_gap_busy", 32'(busy_a), 32'd0);
      chk("b2b_rdata1", rdata_a, 32'h00000033);
      step();
      chk("b2b_reaccept", 32'(busy_a), 32'd1);
      chk("b2b_done_low", 32'(done_a), 32'd0);
      req_v[0] = 1'b0; addr = 24'h000001;
      step();
      chk("b2b_done2", 32'(done_a), 32'd1);
      chk("b2b_rdata2", rdata_a, 32'h00000044);
      step();
      chk("b2b_no_req", 32'(busy_a), 32'd0);

      // reset during beat 1 of a 3-beat write
      wr = 1'b1; size = 2'd2; addr = 24'h000201; wdata = 32'hAABBCCDD; req_v[0] = 1'b1;
      dc = 0;
      while (!busy_a && dc < 20) begin step(); dc++; end
      req_v[0] = 1'b0;
      step();
      chk("mid_addr", 32'(bus_addr_a), 32'h202);
      dc = done_cnt[0];
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_done", 32'(done_a), 32'd0);
      chk("mid_rst_addr", 32'(bus_addr_a), 32'd0);
      chk("mid_rst_din", 32'(bus_din_a), 32'd0);
      chk("mid_rst_we", 32'(bus_we_a), 32'd0);
      chk("mid_rst_rd", 32'(bus_rd_a), 32'd0);
      chk("mid_rst_rdata", rdata_a, 32'd0);
      step(); step(); step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("mid_rst_no_done", 32'(done_cnt[0]), 32'(dc));
      chk("mid_rst_idle", 32'(busy_a), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jt900h_memctl.md
# jt900h_memctl

Parametrised external-bus access unit for the JT900H core, generalising the fixed 16-bit memory interface. It takes one request at a time from the control unit: a byte, word or long read or write at any byte address. Each request is split into aligned bus beats for an 8- or 16-bit little-endian bus, with programmable and external wait states. Read data is assembled into a 32-bit result, and the unit reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `BW`, 16: external data bus width in bits; legal values are 8 and 16.
- `AW`, 24: address width in bits.
- `WAIT`, 0: fixed wait states per beat, 0..7.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cen` in 1: clock enable; all state advances only on `clk` edges with `cen`=1.
- `req` in 1: access request, sampled while idle.
- `wr` in 1: 1=write, 0=read.
- `size` in 2: 0=byte, 1=word, 2=long, 3=treated as long.
- `addr` in AW: byte address of the least-significant byte.
- `wdata` in 32: write data, right-aligned.
- `rdata` out 32: read result, zero-extended for byte/word.
- `busy` out 1: access in progress.
- `done` out 1: one-cen-cycle completion pulse.
- `bus_addr` out AW: beat address; bit 0 is forced to 0 when BW=16.
- `bus_din` out BW: write data to memory.
- `bus_dout` in BW: read data from memory.
- `bus_we` out BW/8: per-byte-lane write enable; lane 0 is bits [7:0] and the even address.
- `bus_rd` out 1: read strobe.
- `bus_wait` in 1: external stall; extends the current beat while high.

## Operation
- Reset: `rdata`, `busy`, `done`, `bus_addr`, `bus_din`, `bus_we` and `bus_rd` are all 0. Reset mid-access abandons the access with no completion pulse.
- The state machine has three states: IDLE, BEAT and LAST. LAST is BEAT with no further beats pending.
- IDLE, `req`=1 on a cen edge:
  - Latch `wr`, `size`, `addr` and `wdata`.
  - Compute the beat count N.
  - Drive beat 0 on the same edge and set `busy`=1.
- Beat count N is the number of BW-aligned units covering bytes addr..addr+bytes-1, where bytes = 1, 2 or 4.
  - BW=16: byte gives 1; word gives 1 (even) or 2 (odd); long gives 2 (even) or 3 (odd).
  - BW=8: N = bytes.
- Beat k address: aligned(addr) + k*(BW/8), modulo 2^AW. Wrap from the top of the address space to 0 is legal.
- Write beat:
  - Each byte sits on the lane given by its address bit 0 (BW=16).
  - `bus_we` is set only for the lanes that carry requested bytes. Unused lanes of `bus_din` are 0.
- Read beat:
  - `bus_rd`=1 for the whole beat. `bus_we` is 0.
  - Requested lanes are captured into the matching byte positions of an internal accumulator.
- The beat counter reloads to WAIT at each beat start. A beat ends on the cen edge where the counter is 0 and `bus_wait`=0; otherwise the counter decrements, saturating at 0.
- At beat end:
  - If more beats remain, the next beat's address, data and strobes are driven on that same edge, with no idle cycle.
  - Otherwise: `busy`<=0 and `done`<=1. `bus_rd`, `bus_we` and `bus_addr` drop to 0. For reads, `rdata` <= accumulator with unrequested bytes zeroed.
- `rdata` holds its value until the next read completes; writes leave it unchanged.
- `req` while `busy`=1 is ignored; it is not queued.
- With `cen`=0 everything freezes, including the wait counter; `bus_wait` is not sampled.

## Timing
- Accept edge E0. Each beat lasts (WAIT+1+stall cycles) cen edges. `done` rises at edge E0 + N*(WAIT+1) + total stalls and falls on the next cen edge.
- The earliest new acceptance is the cen edge after `done` rises, so there is a minimum 1-cycle gap between accesses.
- Strobes (`bus_rd`/`bus_we`) are held for the full beat, including wait and stall cycles. Strobes are not pulsed.
- Output registers only; no combinational path from `req` or `bus_dout` to any output.

## Test plan
- Read test, BW=16, WAIT=0:
  - Stimulus: long read at 0x000100, memory holds bytes 11 22 33 44.
  - Required: 2 beats at 0x100 and 0x102, `done` 2 cycles after accept, `rdata`=0x44332211.
- Unaligned write, BW=16:
  - Stimulus: long write 0xAABBCCDD at 0x000201.
  - Required: 3 beats.
    - Beat at 0x200: we=2'b10, din=0xDD00.
    - Beat at 0x202: we=2'b11, din=0xBBCC.
    - Beat at 0x204: we=2'b01, din=0x00AA.
- Wait states, WAIT=2:
  - Stimulus: odd word read at 0x000011, with `bus_wait` high for 2 cycles on beat 1.
  - Required: beat 0 lasts 3 cycles and beat 1 lasts 5. `bus_rd` stays high throughout, and `done` arrives 8 cycles after accept.
- BW=8 and address wrap:
  - Stimulus: long read at 0xFFFFFE.
  - Required: addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001, with bytes assembled LSB-first.
- Reset mid-access and `cen` gating:
  - Stimulus: reset asserted during beat 1 of a 3-beat write; also `cen` toggled at 50% during a read.
  - Required, reset: all outputs 0 immediately and no `done`.
  - Required, `cen` gating: the cen-gated read gives the same result and beat count as the ungated one.
- Back-to-back and ignored requests:
  - Stimulus: `req` held high continuously with byte reads.
  - Required: accesses are separated by one idle cycle. A `req` change during `busy` has no effect, and byte `rdata` upper 24 bits are 0.
